// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: CPU pushes bytes into a TX FIFO, a bit-serial engine shifts them out LSB first.
// Latency: a byte written into an empty FIFO drives the start bit two edges after the write (one IDLE cycle); frame = 10*bit_div clocks.
// Backpressure: none on the bus; firmware polls STATUS. A push into a full FIFO is dropped and sets sticky overflow unless a pop coincides.
//
// Ports:
//   clock, reset     - system clock, synchronous active-high reset
//   we, addr, wd     - register write strobe, register select (0 TXDATA, 1 STATUS, 2 DIV, 3 CTRL), write data
//   rd               - combinational read data for the selected register
//   tx               - registered serial line, idles high
//   tx_idle          - FIFO empty and engine in IDLE
module uart_tx_periph #(
    parameter int FIFO_DEPTH  = 8,
    parameter int DEFAULT_DIV = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        tx,
    output logic        tx_idle
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]      DEF_DIV_C = DEFAULT_DIV[15:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    // ---------------- register / FIFO state ----------------
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      div_q, div_d;
    logic             en_q, en_d;

    // ---------------- engine state ----------------
    state_e      state_q;
    logic        tx_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_cnt_q;
    logic [15:0] div_cnt_q;
    logic [15:0] bit_div_q;

    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push_req;
    logic push_ok;
    logic ovf_set;
    logic ovf_clr;
    logic bit_end;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);

    // The engine only consumes a byte on its IDLE->START transition.
    assign pop      = (state_q == S_IDLE) && en_q && !fifo_empty;
    assign push_req = we && (addr == 2'd0);
    // A coinciding pop frees a slot in the same edge, so a "full" push still fits.
    assign push_ok  = push_req && (!fifo_full || pop);
    assign ovf_set  = push_req && fifo_full && !pop;
    assign ovf_clr  = we && (addr == 2'd3) && wd[1];

    assign bit_end  = (div_cnt_q == bit_div_q - 16'd1);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        div_d    = div_q;
        en_d     = en_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Set has priority over a simultaneous clear.
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end

        if (we && (addr == 2'd2)) begin
            div_d = wd[15:0];
        end
        if (we && (addr == 2'd3)) begin
            en_d = wd[0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            div_q    <= DEF_DIV_C;
            en_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            div_q    <= div_d;
            en_q     <= en_d;
        end
    end

    // Storage is not reset; emptiness is tracked by count/pointers alone.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wd[7:0];
        end
    end

    // ---------------- bit-serial engine ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            tx_q      <= 1'b1;
            shift_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            div_cnt_q <= 16'd0;
            bit_div_q <= (DEF_DIV_C == 16'd0) ? 16'd1 : DEF_DIV_C;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q   <= mem_q[rd_ptr_q];
                        // Divisor is frozen per frame; DIV writes land at the next frame.
                        bit_div_q <= (div_q == 16'd0) ? 16'd1 : div_q;
                        bit_cnt_q <= 3'd0;
                        div_cnt_q <= 16'd0;
                        tx_q      <= 1'b0;
                        state_q   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        div_cnt_q <= 16'd0;
                        tx_q      <= shift_q[0];
                        state_q   <= S_DATA;
                    end else begin
                        div_cnt_q <= div_cnt_q + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        div_cnt_q <= 16'd0;
                        if (bit_cnt_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            // shift_q[1] is the next bit once the register shifts.
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        div_cnt_q <= 16'd0;
                        state_q   <= S_IDLE;
                    end else begin
                        div_cnt_q <= div_cnt_q + 16'd1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tx      = tx_q;
    assign tx_idle = fifo_empty && (state_q == S_IDLE);

    // ---------------- read mux ----------------
    logic [3:0] cnt_disp;

    always_comb begin
        cnt_disp = (32'(count_q) > 32'd15) ? 4'hF : 4'(count_q);
        rd       = 32'h0;
        unique case (addr)
            2'd0: rd = 32'h0;
            2'd1: rd = {24'h0, ovf_q, (state_q != S_IDLE), fifo_full, fifo_empty, cnt_disp};
            2'd2: rd = {16'h0, div_q};
            2'd3: rd = {31'h0, en_q};
            default: rd = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph: behavioural frame/queue model checked every cycle plus literal expectations.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_periph;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        we    = 1'b0;
    logic [1:0]  addr  = 2'd1;
    logic [31:0] wd    = 32'h0;
    logic [31:0] rd;
    logic        tx;
    logic        tx_idle;

    int checks = 0;
    int errors = 0;

    uart_tx_periph #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16)) dut (
        .clock  (clock),
        .reset  (reset),
        .we     (we),
        .addr   (addr),
        .wd     (wd),
        .rd     (rd),
        .tx     (tx),
        .tx_idle(tx_idle)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A frame is 10 symbols of m_bd clocks each; m_t counts clocks since the start bit began.
    logic [7:0]  mq[$];
    logic        m_ovf;
    logic        m_en;
    logic [15:0] m_div;
    logic        m_act;
    int          m_t;
    int          m_bd;
    logic [7:0]  m_cur;
    logic        m_valid = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_en    = 1'b1;
            m_div   = 16'd16;
            m_act   = 1'b0;
            m_t     = 0;
            m_bd    = 16;
            m_cur   = 8'h00;
            m_valid = 1'b1;
        end else if (m_valid) begin
            int   sz;
            logic pop;
            logic set;
            sz  = mq.size();
            pop = !m_act && m_en && (sz > 0);
            set = 1'b0;
            if (m_act) begin
                m_t++;
                if (m_t == 10 * m_bd) m_act = 1'b0;
            end else if (pop) begin
                m_cur = mq.pop_front();
                m_bd  = (m_div == 16'd0) ? 1 : int'(m_div);
                m_t   = 0;
                m_act = 1'b1;
            end
            if (we && addr == 2'd0) begin
                if (sz < DEPTH || pop) mq.push_back(wd[7:0]);
                else set = 1'b1;
            end
            if (we && addr == 2'd3) begin
                m_en = wd[0];
                if (wd[1]) m_ovf = 1'b0;
            end
            if (set) m_ovf = 1'b1;
            if (we && addr == 2'd2) m_div = wd[15:0];
        end
    end

    function automatic logic m_tx();
        int idx;
        if (!m_act) return 1'b1;
        idx = m_t / m_bd;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return m_cur[idx-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_rd(input logic [1:0] a);
        int n;
        logic [31:0] r;
        n = mq.size();
        r = 32'h0;
        case (a)
            2'd1: begin
                r[3:0] = (n > 15) ? 4'hF : 4'(n);
                r[4]   = (n == 0);
                r[5]   = (n == DEPTH);
                r[6]   = m_act;
                r[7]   = m_ovf;
            end
            2'd2: r = {16'h0, m_div};
            2'd3: r = {31'h0, m_en};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    always @(negedge clock) begin
        if (m_valid) begin
            chk("model_tx", {31'h0, tx}, {31'h0, m_tx()});
            chk("model_tx_idle", {31'h0, tx_idle}, {31'h0, (!m_act && mq.size() == 0)});
            chk("model_rd", rd, m_rd(addr));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we   = 1'b1;
        addr = a;
        wd   = d;
        tick();
        we   = 1'b0;
        addr = 2'd1;
        wd   = 32'h0;
    endtask

    task automatic rdchk(input logic [1:0] a, input logic [31:0] exp, input string name);
        addr = a;
        #1;
        chk(name, rd, exp);
        addr = 2'd1;
    endtask

    task automatic wait_idle(input int bound, input string name);
        int n;
        n = 0;
        while (tx_idle !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        chk(name, {31'h0, tx_idle}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] pat;
        int run;
        int runs[$];

        // 1. reset values
        tick();
        tick();
        reset = 1'b0;
        rdchk(2'd1, 32'h10, "reset_status");
        rdchk(2'd2, 32'd16, "reset_div");
        rdchk(2'd3, 32'h1, "reset_ctrl");
        rdchk(2'd0, 32'h0, "reset_txdata");
        chk("reset_tx", {31'h0, tx}, 32'h1);
        chk("reset_tx_idle", {31'h0, tx_idle}, 32'h1);

        // 2. single 0xA5 frame at 4 clocks/bit
        pat = 10'b1101001010;
        wr(2'd2, 32'd4);
        wr(2'd0, 32'hA5);
        chk("one_idle_cycle_tx", {31'h0, tx}, 32'h1);
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("frame_a5_tx", {31'h0, tx}, {31'h0, pat[i/4]});
            chk("frame_a5_busy", {31'h0, rd[6]}, 32'h1);
        end
        tick();
        chk("frame_a5_idle_after", {31'h0, tx_idle}, 32'h1);

        // 3. fill while disabled, overflow, clear, drain in order
        wr(2'd3, 32'h0);
        for (int k = 0; k < 9; k++) wr(2'd0, k);
        rdchk(2'd1, 32'hA8, "full_overflow_status");
        wr(2'd3, 32'h3);
        rdchk(2'd1, 32'h28, "overflow_cleared_status");
        rdchk(2'd3, 32'h1, "ctrl_clear_bit_reads_0");
        wait_idle(2000, "drain8_timeout");
        rdchk(2'd1, 32'h10, "drained_status");

        // 4. DIV change mid-frame applies to the next frame only
        wr(2'd3, 32'h0);
        wr(2'd2, 32'd2);
        wr(2'd0, 32'hFF);
        wr(2'd0, 32'h00);
        wr(2'd3, 32'h1);
        run = 0;
        for (int i = 0; i < 200; i++) begin
            if (i == 3) begin
                we = 1'b1; addr = 2'd2; wd = 32'd6;
            end else begin
                we = 1'b0; addr = 2'd1; wd = 32'h0;
            end
            tick();
            if (tx == 1'b0) run++;
            else if (run > 0) begin
                runs.push_back(run);
                run = 0;
            end
        end
        we = 1'b0; addr = 2'd1; wd = 32'h0;
        chk("div_runs_count", (runs.size() >= 2) ? 32'h1 : 32'h0, 32'h1);
        if (runs.size() >= 2) begin
            chk("div_old_start_len", runs[0], 32'd2);
            chk("div_new_low_len", runs[1], 32'd54);
        end
        wait_idle(500, "div_drain_timeout");

        // 5. reset mid-frame
        wr(2'd0, 32'h55);
        for (int i = 0; i < 10; i++) tick();
        chk("pre_reset_busy", {31'h0, rd[6]}, 32'h1);
        reset = 1'b1;
        tick();
        chk("reset_mid_tx", {31'h0, tx}, 32'h1);
        rdchk(2'd1, 32'h10, "reset_mid_status");
        rdchk(2'd2, 32'd16, "reset_mid_div");
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("post_reset_quiet", {31'h0, tx}, 32'h1);
        end

        // 6. push on the pop cycle with a full FIFO; DIV=0 behaves as 1
        wr(2'd2, 32'd0);
        rdchk(2'd2, 32'd0, "div_zero_reads_0");
        wr(2'd3, 32'h0);
        for (int k = 0; k < 8; k++) wr(2'd0, 32'h10 + k);
        rdchk(2'd1, 32'h28, "full_no_ovf_status");
        wr(2'd3, 32'h1);
        wr(2'd0, 32'h99);
        rdchk(2'd1, 32'h68, "push_on_pop_status");
        wait_idle(1000, "final_drain_timeout");
        rdchk(2'd1, 32'h10, "final_status");

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_periph.md
Name: uart_tx_periph

Overview:
Memory-mapped UART transmitter peripheral on the SoC data bus, alongside the factorial and GPIO peripherals. It is decoded at address window 0xAxx (address[11:8] == 4'd10). The CPU issues SW to push bytes into a TX FIFO. A bit-serial engine emits the bytes as 8N1 frames on a single output line. LW returns status, divisor and control so firmware can poll before writing.

Parameters:
FIFO_DEPTH, 8, TX FIFO entries (power of 2, >= 2).
DEFAULT_DIV, 16, reset value of clocks-per-bit divisor.

Ports:
clock  input  1  system clock.
reset  input  1  synchronous, active-high reset.
we  input  1  write strobe from address decoder (dmem_we_req gated by 0xAxx decode).
addr  input  2  register select, driven from alu_out[3:2].
wd  input  32  write data (dmem_wd).
rd  output  32  read data to the SoC read mux.
tx  output  1  serial line, idle high.
tx_idle  output  1  high when FIFO is empty and the engine is in IDLE.

Behaviour:
Register map (addr):
- 0 TXDATA: write pushes wd[7:0]. Read returns 0.
- 1 STATUS (read-only, writes ignored):
  - bits [3:0] fifo_count (saturates display at 15).
  - bit 4 fifo_empty, bit 5 fifo_full, bit 6 busy (engine not IDLE), bit 7 overflow (sticky).
  - all other bits 0.
- 2 DIV: bits [15:0] clocks-per-bit. Read returns current register value; upper bits read 0.
- 3 CTRL: bit0 enable (R/W), bit1 clear_overflow (write-1 pulse, reads 0).

Read path:
- rd is combinational from addr and current state; no read side effects.
- Matches the single-cycle CPU load timing.

Reset values:
- tx=1, tx_idle=1, FIFO empty, count=0, overflow=0, DIV=DEFAULT_DIV, enable=1, FSM=IDLE, rd reflects these values.

FIFO:
- Circular buffer with rd/wr pointers of log2(FIFO_DEPTH) bits that wrap modulo depth; count is log2(FIFO_DEPTH)+1 bits.
- Push on we && addr==0.
- Push when full is dropped and sets overflow, except when a pop occurs in the same cycle; that push is accepted and count stays unchanged.
- Push and pop in the same cycle with count between 1 and DEPTH-1: count unchanged.
- Pop happens only on the IDLE->START transition.

Engine FSM (IDLE, START, DATA, STOP):
- IDLE: tx=1. If enable && !fifo_empty, then pop into shift register, latch bit_div = max(DIV,1), clear bit counter, go to START.
- START: tx=0 for bit_div clocks, then DATA.
- DATA: tx=shift[0], LSB first. Each bit lasts bit_div clocks. After 8 bits go to STOP.
- STOP: tx=1 for bit_div clocks, then IDLE. A new frame can start the following cycle, giving back-to-back frames with no extra idle bit.
- Frame length is exactly 10*bit_div clocks from the START entry to the IDLE return, plus 1 IDLE cycle between frames.

Timing and control rules:
- A DIV write mid-frame takes effect only at the next START latch.
- DIV=0 is treated as 1.
- Clearing enable mid-frame completes the current frame. No further pops occur while enable=0, and FIFO contents are retained.
- clear_overflow and a simultaneous overflowing push: the set wins, so overflow stays 1.
- Reset mid-frame: tx returns to 1 on the next edge. FIFO contents are discarded and all registers return to reset values.

tx_idle = fifo_empty && state==IDLE, registered-state derived.

Integration: the top-level decoder adds a we3 case for 4'd10, and the read mux is widened to select rd.

Test Plan:
1. Reset, then read addr 1/2/3 -> STATUS=0x10, DIV=16, CTRL=0x1, tx=1, tx_idle=1.
2. Write DIV=4, write TXDATA=0xA5 -> after 1 IDLE cycle, tx = 0,1,0,1,0,0,1,0,1,1, each held 4 clocks (40 clocks); busy=1 during the frame; tx_idle returns to 1 afterwards.
3. Write enable=0, then 9 writes of 0x00..0x08 -> count=8, full=1, overflow=1, byte 0x08 discarded. Write CTRL=0x3 -> overflow=0. Transmitted order is 0x00..0x07, back-to-back.
4. DIV=2, start a frame with 0xFF, write DIV=6 during DATA -> the current frame keeps 2 clocks/bit; the next queued frame uses 6 clocks/bit.
5. Assert reset during DATA of a 0x55 frame -> the next cycle shows tx=1, count=0, DIV=16, and no further transitions on tx.
6. With FIFO full, issue a TXDATA write on the exact cycle the engine pops -> write accepted, count stays 8, overflow stays 0.
